regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard. It is the successor to the fixed 32x32 two-read/one-write `RegFile` and sits between the decode stage, which reads operands and issues destinations, and writeback. Relative to `RegFile` it adds:
- configurable width and depth (RV32I or RV32E);
- hardwired-zero `x0`;
- optional write-to-read bypass;
- synchronous reset;
- pending/hazard tracking so decode can stall on read-after-write hazards.

## Interface
Parameters
- XLEN, 32, data width in bits.
- DEPTH, 32, number of architectural registers; legal values are 16 (RV32E) and 32.
- AW, $clog2(DEPTH), address width; derived, never overridden.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read outputs; 0 = reads return the stored value only.

Ports
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  writeback enable.
- write_addr  in  AW  writeback destination.
- din  in  XLEN  writeback data.
- read_addr0  in  AW  operand 0 address.
- read_addr1  in  AW  operand 1 address.
- dout0  out  XLEN  operand 0 data (combinational).
- dout1  out  XLEN  operand 1 data (combinational).
- issue  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  AW  destination of the issued instruction.
- pending0  out  1  the register at read_addr0 has an outstanding write.
- pending1  out  1  the register at read_addr1 has an outstanding write.
- hazard  out  1  pending0 | pending1.

## Operation
- Storage: DEPTH x XLEN flops, plus a DEPTH-bit pending vector `pend`.
- Register 0 always reads 0:
  - writes to it are dropped;
  - issue to it never sets `pend[0]`;
  - `pend[0]` is constantly 0.
- Read, per port p:
  - if read_addr_p == 0, dout_p = 0;
  - else if BYPASS && we && write_addr == read_addr_p, dout_p = din;
  - else dout_p = regs[read_addr_p].
- Write: on a rising edge with we && write_addr != 0, regs[write_addr] <= din.
- Scoreboard update each edge, for every register r != 0:
  - set when issue && issue_rd == r;
  - clear when we && write_addr == r;
  - set and clear in the same cycle for the same r: set wins, because the new producer is younger than the retiring one;
  - otherwise hold.
- pending_p = pend[read_addr_p], except that it is forced to 0 when BYPASS && we && write_addr == read_addr_p, since the value is available this cycle.
- Only one outstanding write per register is tracked. Decode must not issue a second writer to a register that is still pending; if it does, the first writeback clears the bit early. This is documented behaviour, not an error.
- Addresses at or above DEPTH (only possible when DEPTH=16 with a wider external bus) cannot occur: AW truncates them.

## Timing
- Reset, evaluated at the clk edge while rst=1:
  - every register becomes 0 and every pend bit becomes 0;
  - consequently dout0 = dout1 = 0 and pending0 = pending1 = hazard = 0 from the first cycle after the reset edge;
  - during reset cycles, we and issue are ignored.
- Reset asserted mid-operation: all in-flight pending bits are discarded on that edge, and a writeback arriving after reset updates the register normally.
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- With BYPASS=0, data written at edge N is visible from the cycle after edge N; a same-cycle read returns the old value and pending remains 1.
- Issue at edge N makes pending visible from cycle N+1.
- An issue in the same cycle as a read of that register does not raise pending in that cycle.

## Test plan
1. Reset: preload r5 = 0xDEADBEEF, then assert rst for 1 cycle -> dout0 = 0 for read_addr0 = 5; pending0 = 0.
2. x0: we=1, write_addr=0, din=0xFFFFFFFF; issue_rd=0 -> next cycle dout0 = 0 and pending0 = 0 at read_addr0 = 0.
3. Bypass: BYPASS=1, r7 = 0x11; same cycle we=1, write_addr=7, din=0x22, read_addr1=7 -> dout1 = 0x22 that cycle. BYPASS=0 -> dout1 = 0x11 that cycle, 0x22 the next.
4. Scoreboard RAW: issue r3 at edge N -> pending0 = 1 and hazard = 1 while read_addr0 = 3; writeback r3 = 0x55 -> pending clears, dout0 = 0x55.
5. Simultaneous set/clear: pend[9] = 1; in one cycle issue_rd=9 and we with write_addr=9 -> next cycle pending = 1 and r9 holds the new din.
6. DEPTH=16: write r15 = 0xA5A5A5A5 and read it on both ports -> both return 0xA5A5A5A5; after a full reset sweep, all 16 registers read 0.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// Integer register file with a per-register pending-write scoreboard. It sits
// between decode (reads operands, issues destinations) and writeback. Decode
// can use pending0/pending1/hazard to stall on read-after-write hazards.
//
// Parameters
//   XLEN   - data width in bits
//   DEPTH  - number of architectural registers (16 for RV32E, 32 for RV32I)
//   BYPASS - 1: a same-cycle writeback is forwarded to the read ports
//            0: reads always return the stored value
//   AW     - address width, derived from DEPTH
//
// Ports
//   clk         in   single clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset (clears data and pend)
//   we          in   writeback enable
//   write_addr  in   writeback destination
//   din         in   writeback data
//   read_addr0  in   operand 0 address
//   read_addr1  in   operand 1 address
//   dout0       out  operand 0 data (combinational)
//   dout1       out  operand 1 data (combinational)
//   issue       in   decode issues an instruction that will write issue_rd
//   issue_rd    in   destination of the issued instruction
//   pending0    out  register at read_addr0 has an outstanding write
//   pending1    out  register at read_addr1 has an outstanding write
//   hazard      out  pending0 | pending1
//
// Register 0 is hardwired to zero: it has no storage, writes to it are
// dropped and an issue to it never marks it pending.
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] din,
    input  logic [AW-1:0]   read_addr0,
    input  logic [AW-1:0]   read_addr1,
    output logic [XLEN-1:0] dout0,
    output logic [XLEN-1:0] dout1,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    output logic            pending0,
    output logic            pending1,
    output logic            hazard
);

    // Read view of the storage and of the scoreboard. Each element is driven
    // by exactly one generate block below.
    logic [XLEN-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;

    // -------------------------------------------------------------------------
    // Storage and scoreboard, one slice per architectural register
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0: no flops at all, constant zero data and never pending.
                assign regs[gi] = '0;
                assign pend[gi] = 1'b0;
            end else begin : g_live
                logic [XLEN-1:0] data_reg;
                logic [XLEN-1:0] data_next;
                logic            pend_reg;
                logic            pend_next;
                logic            wr_hit;
                logic            iss_hit;

                assign wr_hit  = we    && (write_addr == AW'(gi));
                assign iss_hit = issue && (issue_rd   == AW'(gi));

                always_comb begin
                    data_next = data_reg;
                    if (wr_hit) begin
                        data_next = din;
                    end
                end

                // A set and a clear on the same edge keep the bit set: the
                // newly issued producer is younger than the one retiring.
                // Only one producer per register is tracked, so a second
                // issue before writeback is cleared by the first writeback.
                always_comb begin
                    pend_next = pend_reg;
                    if (iss_hit) begin
                        pend_next = 1'b1;
                    end else if (wr_hit) begin
                        pend_next = 1'b0;
                    end
                end

                // Reset takes priority, so we/issue are ignored while rst=1
                // and all in-flight pending bits are dropped.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        data_reg <= '0;
                        pend_reg <= 1'b0;
                    end else begin
                        data_reg <= data_next;
                        pend_reg <= pend_next;
                    end
                end

                assign regs[gi] = data_reg;
                assign pend[gi] = pend_reg;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [AW-1:0]   port_addr [2];
    logic [XLEN-1:0] port_data [2];
    logic            port_pend [2];

    assign port_addr[0] = read_addr0;
    assign port_addr[1] = read_addr1;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic fwd;

            // Forwarding applies only when enabled; address 0 is handled
            // separately so a dropped write to x0 is never forwarded.
            assign fwd = BYPASS && we && (write_addr == port_addr[gi]);

            always_comb begin
                port_data[gi] = regs[port_addr[gi]];
                if (port_addr[gi] == '0) begin
                    port_data[gi] = '0;
                end else if (fwd) begin
                    port_data[gi] = din;
                end
            end

            // A forwarded value is available now, so the consumer need not
            // stall even though the scoreboard bit is still set.
            assign port_pend[gi] = pend[port_addr[gi]] & ~fwd;
        end
    endgenerate

    assign dout0    = port_data[0];
    assign dout1    = port_data[1];
    assign pending0 = port_pend[0];
    assign pending1 = port_pend[1];
    assign hazard   = port_pend[0] | port_pend[1];

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
//
// Three instances share one stimulus stream:
//   u_b1  : XLEN=32, DEPTH=32, BYPASS=1 (main checked instance)
//   u_b0  : XLEN=32, DEPTH=32, BYPASS=0
//   u_d16 : XLEN=32, DEPTH=16, BYPASS=1 (low 4 address bits)
// A vector table exercises the main function; hand-written sequences cover
// bypass-off timing, reset mid-operation and the 16-entry configuration.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  write_addr;
    logic [31:0] din;
    logic [4:0]  read_addr0;
    logic [4:0]  read_addr1;
    logic        issue;
    logic [4:0]  issue_rd;

    logic [31:0] b1_dout0, b1_dout1, b0_dout0, b0_dout1, d_dout0, d_dout1;
    logic        b1_p0, b1_p1, b1_hz, b0_p0, b0_p1, b0_hz, d_p0, d_p1, d_hz;

    int checks;
    int failures;

    regfile_sb #(.XLEN(32), .DEPTH(32), .BYPASS(1'b1)) u_b1 (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
        .read_addr0(read_addr0), .read_addr1(read_addr1),
        .dout0(b1_dout0), .dout1(b1_dout1),
        .issue(issue), .issue_rd(issue_rd),
        .pending0(b1_p0), .pending1(b1_p1), .hazard(b1_hz)
    );

    regfile_sb #(.XLEN(32), .DEPTH(32), .BYPASS(1'b0)) u_b0 (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .din(din),
        .read_addr0(read_addr0), .read_addr1(read_addr1),
        .dout0(b0_dout0), .dout1(b0_dout1),
        .issue(issue), .issue_rd(issue_rd),
        .pending0(b0_p0), .pending1(b0_p1), .hazard(b0_hz)
    );

    regfile_sb #(.XLEN(32), .DEPTH(16), .BYPASS(1'b1)) u_d16 (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr[3:0]), .din(din),
        .read_addr0(read_addr0[3:0]), .read_addr1(read_addr1[3:0]),
        .dout0(d_dout0), .dout1(d_dout1),
        .issue(issue), .issue_rd(issue_rd[3:0]),
        .pending0(d_p0), .pending1(d_p1), .hazard(d_hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the bench is purely cycle-counted, this only guards a stall.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic w, input logic [4:0] wa, input logic [31:0] d,
                          input logic [4:0] r0, input logic [4:0] r1,
                          input logic is, input logic [4:0] ird);
        we = w; write_addr = wa; din = d;
        read_addr0 = r0; read_addr1 = r1;
        issue = is; issue_rd = ird;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 1 unit later, well away from the next edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] din;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        iss;
        logic [4:0]  ird;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ep0;
        logic        ep1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        checks   = 0;
        failures = 0;

        //            we   wa    din            ra0   ra1   iss  ird    e0             e1            ep0   ep1
        tbl[0]  = '{1'b1, 5'd7,  32'h0000_0011, 5'd7, 5'd0, 1'b0, 5'd0,  32'h0000_0011, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,         5'd7, 5'd7, 1'b1, 5'd3,  32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,         5'd3, 5'd7, 1'b0, 5'd0,  32'h0,         32'h0000_0011, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 5'd3,  32'h0000_0055, 5'd3, 5'd3, 1'b0, 5'd0,  32'h0000_0055, 32'h0000_0055, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,         5'd3, 5'd0, 1'b1, 5'd9,  32'h0000_0055, 32'h0,        1'b0, 1'b0};
        tbl[5]  = '{1'b1, 5'd9,  32'h0000_0099, 5'd9, 5'd5, 1'b1, 5'd9,  32'h0000_0099, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,         5'd9, 5'd9, 1'b0, 5'd0,  32'h0000_0099, 32'h0000_0099, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd9, 1'b1, 5'd0,  32'h0,         32'h0000_0099, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,         5'd0, 5'd0, 1'b0, 5'd0,  32'h0,         32'h0,        1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,         5'd12, 5'd9, 1'b1, 5'd12, 32'h0,        32'h0000_0099, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 5'd0,  32'h0,         5'd12, 5'd0, 1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0};

        // ---------------- reset and reset state ----------------
        set_in(1'b1, 5'd4, 32'h1234_5678, 5'd5, 5'd4, 1'b1, 5'd5);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd4, 1'b0, 5'd0);
        #1;
        $display("reset: dout0=%h dout1=%h pending0=%b pending1=%b", b1_dout0, b1_dout1, b1_p0, b1_p1);
        chk("reset_dout0", b1_dout0, 32'h0);
        chk("reset_dout1", b1_dout1, 32'h0);
        chk("reset_pending0", {31'b0, b1_p0}, 32'h0);
        chk("reset_hazard", {31'b0, b1_hz}, 32'h0);

        // ---------------- table-driven main function ----------------
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].ra0, tbl[i].ra1, tbl[i].iss, tbl[i].ird);
            #1;
            $display("vec %0d: we=%b wa=%0d din=%h ra0=%0d ra1=%0d iss=%b ird=%0d -> d0=%h d1=%h p0=%b p1=%b hz=%b",
                     i, tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].ra0, tbl[i].ra1, tbl[i].iss, tbl[i].ird,
                     b1_dout0, b1_dout1, b1_p0, b1_p1, b1_hz);
            chk($sformatf("vec%0d_dout0", i), b1_dout0, tbl[i].e0);
            chk($sformatf("vec%0d_dout1", i), b1_dout1, tbl[i].e1);
            chk($sformatf("vec%0d_pending0", i), {31'b0, b1_p0}, {31'b0, tbl[i].ep0});
            chk($sformatf("vec%0d_pending1", i), {31'b0, b1_p1}, {31'b0, tbl[i].ep1});
            chk($sformatf("vec%0d_hazard", i), {31'b0, b1_hz}, {31'b0, tbl[i].ep0 | tbl[i].ep1});
            next_cycle();
        end

        // ---------------- bypass on vs off (r7 holds 0x11) ----------------
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b1, 5'd7);
        next_cycle();
        set_in(1'b1, 5'd7, 32'h0000_0022, 5'd0, 5'd7, 1'b0, 5'd0);
        #1;
        $display("bypass same cycle: b1 d1=%h p1=%b  b0 d1=%h p1=%b", b1_dout1, b1_p1, b0_dout1, b0_p1);
        chk("byp1_same_dout1", b1_dout1, 32'h0000_0022);
        chk("byp1_same_pending1", {31'b0, b1_p1}, 32'h0);
        chk("byp0_same_dout1", b0_dout1, 32'h0000_0011);
        chk("byp0_same_pending1", {31'b0, b0_p1}, 32'h1);
        chk("byp0_same_hazard", {31'b0, b0_hz}, 32'h1);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
        #1;
        $display("bypass next cycle: b1 d1=%h  b0 d1=%h p1=%b", b1_dout1, b0_dout1, b0_p1);
        chk("byp0_next_dout1", b0_dout1, 32'h0000_0022);
        chk("byp0_next_pending1", {31'b0, b0_p1}, 32'h0);
        chk("byp1_next_dout1", b1_dout1, 32'h0000_0022);

        // ---------------- reset mid-operation ----------------
        set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b1, 5'd5);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd12, 1'b0, 5'd0);
        #1;
        $display("pre-reset: r5=%h p0=%b r12 p1=%b", b1_dout0, b1_p0, b1_p1);
        chk("prerst_dout0", b1_dout0, 32'hDEAD_BEEF);
        chk("prerst_pending0", {31'b0, b1_p0}, 32'h1);
        chk("prerst_pending1", {31'b0, b1_p1}, 32'h1);
        // we/issue active during the reset edge must be ignored
        set_in(1'b1, 5'd6, 32'hCAFE_0000, 5'd5, 5'd12, 1'b1, 5'd6);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0);
        #1;
        $display("post-reset: r5=%h r6=%h p0=%b p1=%b hz=%b", b1_dout0, b1_dout1, b1_p0, b1_p1, b1_hz);
        chk("rst_r5", b1_dout0, 32'h0);
        chk("rst_r6", b1_dout1, 32'h0);
        chk("rst_pending0", {31'b0, b1_p0}, 32'h0);
        chk("rst_pending1", {31'b0, b1_p1}, 32'h0);
        read_addr1 = 5'd12;
        #1;
        chk("rst_pending_r12", {31'b0, b1_p1}, 32'h0);
        set_in(1'b1, 5'd5, 32'h0000_0123, 5'd0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
        #1;
        $display("write after reset: r5=%h", b1_dout0);
        chk("post_rst_write", b1_dout0, 32'h0000_0123);

        // ---------------- DEPTH=16 ----------------
        set_in(1'b1, 5'd15, 32'hA5A5_A5A5, 5'd0, 5'd0, 1'b0, 5'd0);
        next_cycle();
        set_in(1'b0, 5'd0, 32'h0, 5'd15, 5'd15, 1'b0, 5'd0);
        #1;
        $display("d16 r15: d0=%h d1=%h", d_dout0, d_dout1);
        chk("d16_r15_dout0", d_dout0, 32'hA5A5_A5A5);
        chk("d16_r15_dout1", d_dout1, 32'hA5A5_A5A5);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_addr0 = 5'(i);
            read_addr1 = 5'(15 - i);
            #1;
            $display("d16 sweep %0d: d0=%h d1=%h hz=%b", i, d_dout0, d_dout1, d_hz);
            chk($sformatf("d16_sweep%0d_dout0", i), d_dout0, 32'h0);
            chk($sformatf("d16_sweep%0d_dout1", i), d_dout1, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
